// File: rtl/asu_ddr5_crc_check_x4.sv
`timescale 1ns/1ps
// Receive-side DDR5 x4 write-CRC checker: rebuilds the CRC-8 of an 8-beat burst,
// compares it with the trailing CRC beat and raises result pulses, ALERT_n and an error count.
module asu_ddr5_crc_check_x4 #(
  parameter int ALERT_PW  = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 crc_en_i,
  input  logic                 beat_vld_i,
  input  logic [7:0]           chk_data_i,
  input  logic                 clr_cnt_i,
  output logic                 busy_o,
  output logic                 crc_done_o,
  output logic                 crc_err_o,
  output logic [7:0]           crc_calc_o,
  output logic [7:0]           crc_rx_o,
  output logic                 alert_n_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int            AW         = $clog2(ALERT_PW + 1);
  localparam logic [AW-1:0] ALERT_LOAD = AW'(ALERT_PW);

  typedef enum logic [1:0] {IDLE, DATA, CRCB} state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [7:0]           acc_q, acc_d;
  logic                 mode_q, mode_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [7:0]           calc_q, calc_d;
  logic [7:0]           rx_q, rx_d;
  logic [AW-1:0]        alert_q, alert_d;
  logic [ERR_CNT_W-1:0] errCnt_q, errCnt_d;
  logic [7:0]           contrib;
  logic [7:0]           accNext;

  function automatic logic [7:0] mulX(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h07 : 8'h00);
  endfunction

  // Beat k occupies degrees 8k..8k+7 of the message, so its share of the CRC
  // is the byte times x^(8k+8) mod (x^8+x^2+x+1); shares simply XOR together.
  function automatic logic [7:0] beatContrib(input logic [7:0] b, input logic [2:0] k);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < 64; i++) begin
      if (i < 8 + 8 * int'(k)) v = mulX(v);
    end
    return v;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    calc_d   = calc_q;
    rx_d     = rx_q;
    alert_d  = alert_q;
    errCnt_d = errCnt_q;
    contrib  = beatContrib(chk_data_i, (state_q == IDLE) ? 3'd0 : cnt_q);
    accNext  = acc_q ^ contrib;

    if (beat_vld_i) begin
      case (state_q)
        IDLE: begin
          acc_d   = contrib;
          mode_d  = crc_en_i;
          cnt_d   = 3'd1;
          state_d = DATA;
        end
        DATA: begin
          acc_d = accNext;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (mode_q) begin
              state_d = CRCB;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
              calc_d  = accNext;
            end
          end
        end
        CRCB: begin
          state_d = IDLE;
          done_d  = 1'b1;
          calc_d  = acc_q;
          rx_d    = chk_data_i;
          err_d   = (acc_q != chk_data_i);
        end
        default: state_d = IDLE;
      endcase
    end

    // The alert timer is loaded on the same edge that raises crc_err_o.
    if (err_d) begin
      alert_d = ALERT_LOAD;
    end else if (alert_q != '0) begin
      alert_d = alert_q - AW'(1);
    end

    if (clr_cnt_i) begin
      errCnt_d = err_q ? ERR_CNT_W'(1) : '0;
    end else if (err_q && (errCnt_q != '1)) begin
      errCnt_d = errCnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      acc_q    <= 8'h00;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      calc_q   <= 8'h00;
      rx_q     <= 8'h00;
      alert_q  <= '0;
      errCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      err_q    <= err_d;
      calc_q   <= calc_d;
      rx_q     <= rx_d;
      alert_q  <= alert_d;
      errCnt_q <= errCnt_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign crc_done_o = done_q;
  assign crc_err_o  = err_q;
  assign crc_calc_o = calc_q;
  assign crc_rx_o   = rx_q;
  assign alert_n_o  = (alert_q == '0);
  assign err_cnt_o  = errCnt_q;

endmodule

// File: tb/tb_asu_ddr5_crc_check_x4.sv
`timescale 1ns/1ps
// Bench for asu_ddr5_crc_check_x4: random beat gaps and data against a burst-level
// reference that computes the CRC bit-serially over the whole 64-bit message.
module tb_asu_ddr5_crc_check_x4;

  localparam int ALERT_PW  = 4;
  localparam int ERR_CNT_W = 8;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

  logic                 clk;
  logic                 rst;
  logic                 crcEn;
  logic                 beatVld;
  logic [7:0]           chkData;
  logic                 clrCnt;
  logic                 busy;
  logic                 crcDone;
  logic                 crcErr;
  logic [7:0]           crcCalc;
  logic [7:0]           crcRx;
  logic                 alertN;
  logic [ERR_CNT_W-1:0] errCnt;

  int checks = 0;
  int passes = 0;

  // Reference model state: beats of the open burst and the expected outputs.
  logic [7:0] mBeats[$];
  logic       mMode = 1'b0;
  logic       mInBurst = 1'b0;
  logic       eDone = 1'b0;
  logic       eErr = 1'b0;
  logic [7:0] eCalc = 8'h00;
  logic [7:0] eRx = 8'h00;
  int         eCnt = 0;
  int         cyc = 0;
  int         lastErrCyc = 0;
  logic       haveErr = 1'b0;
  int         lastDoneCyc = 0;

  asu_ddr5_crc_check_x4 #(
    .ALERT_PW (ALERT_PW),
    .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .crc_en_i  (crcEn),
    .beat_vld_i(beatVld),
    .chk_data_i(chkData),
    .clr_cnt_i (clrCnt),
    .busy_o    (busy),
    .crc_done_o(crcDone),
    .crc_err_o (crcErr),
    .crc_calc_o(crcCalc),
    .crc_rx_o  (crcRx),
    .alert_n_o (alertN),
    .err_cnt_o (errCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Message bit 63 enters first, bit 0 last; init 0, no final XOR.
  function automatic logic [7:0] refCrc(input logic [63:0] msg);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = 63; i >= 0; i--) begin
      fb  = crc[7] ^ msg[i];
      crc = {crc[6:0], 1'b0};
      if (fb) crc = crc ^ 8'h07;
    end
    return crc;
  endfunction

  function automatic logic [7:0] burstCrc(input logic [7:0] b [9]);
    logic [63:0] msg;
    for (int k = 0; k < 8; k++) msg[8*k +: 8] = b[k];
    return refCrc(msg);
  endfunction

  function automatic logic expAlertN();
    return !(haveErr && ((cyc - lastErrCyc) < ALERT_PW));
  endfunction

  // Drive one cycle of inputs, let the edge happen, and advance the model.
  task automatic stepCycle(input logic vld, input logic [7:0] d, input logic en,
                           input logic clr, input logic r);
    logic [63:0] msg;
    logic        prevErr;
    beatVld = vld;
    chkData = d;
    crcEn   = en;
    clrCnt  = clr;
    rst     = r;
    if (crcDone === 1'b1) lastDoneCyc = cyc;
    @(posedge clk);
    cyc++;
    if (r) begin
      mBeats.delete();
      mInBurst = 1'b0;
      eDone    = 1'b0;
      eErr     = 1'b0;
      eCalc    = 8'h00;
      eRx      = 8'h00;
      eCnt     = 0;
      haveErr  = 1'b0;
    end else begin
      prevErr = eErr;
      if (clr) eCnt = prevErr ? 1 : 0;
      else if (prevErr && eCnt < CNT_MAX) eCnt++;
      eDone = 1'b0;
      eErr  = 1'b0;
      if (vld) begin
        if (!mInBurst) begin
          mInBurst = 1'b1;
          mMode    = en;
          mBeats.delete();
        end
        mBeats.push_back(d);
        if (mBeats.size() == (mMode ? 9 : 8)) begin
          for (int k = 0; k < 8; k++) msg[8*k +: 8] = mBeats[k];
          eCalc = refCrc(msg);
          if (mMode) begin
            eRx  = mBeats[8];
            eErr = (eCalc != eRx);
          end
          eDone    = 1'b1;
          mInBurst = 1'b0;
          if (eErr) begin
            haveErr    = 1'b1;
            lastErrCyc = cyc;
          end
        end
      end
    end
    #1;
  endtask

  task automatic runBurst(input logic en, input logic [7:0] b [9], input int n,
                          input int gapMax, input logic enHighLater);
    logic [ERR_CNT_W+19:0] got;
    logic [ERR_CNT_W+19:0] exp;
    int                    g;
    logic                  enDrive;
    for (int k = 0; k < n; k++) begin
      g       = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
      enDrive = (k == 0) ? en : (enHighLater ? 1'b1 : en);
      for (int s = 0; s <= g; s++) begin
        if (s < g) stepCycle(1'b0, 8'($urandom), enDrive, 1'b0, 1'b0);
        else       stepCycle(1'b1, b[k], enDrive, 1'b0, 1'b0);
        got = {busy, crcDone, crcErr, alertN, errCnt, crcCalc, crcRx};
        exp = {mInBurst, eDone, eErr, expAlertN(), ERR_CNT_W'(eCnt), eCalc, eRx};
        checks++;
        if (got !== exp) $display("[TB] FAIL burst_cycle cyc=%0d actual=%h required=%h", cyc, got, exp);
        else passes++;
      end
    end
  endtask

  task automatic idleCycles(input int n, input logic clr);
    logic [ERR_CNT_W+19:0] got;
    logic [ERR_CNT_W+19:0] exp;
    for (int i = 0; i < n; i++) begin
      stepCycle(1'b0, 8'h00, 1'b0, clr, 1'b0);
      got = {busy, crcDone, crcErr, alertN, errCnt, crcCalc, crcRx};
      exp = {mInBurst, eDone, eErr, expAlertN(), ERR_CNT_W'(eCnt), eCalc, eRx};
      checks++;
      if (got !== exp) $display("[TB] FAIL idle_cycle cyc=%0d actual=%h required=%h", cyc, got, exp);
      else passes++;
    end
  endtask

  task automatic test_reset();
    stepCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    stepCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({busy, crcDone, crcErr, alertN, errCnt, crcCalc, crcRx} !== {4'b0001, 8'h00, 8'h00, 8'h00})
      $display("[TB] FAIL reset_values actual=%b_%h_%h_%h required=0001_00_00_00",
               {busy, crcDone, crcErr, alertN}, errCnt, crcCalc, crcRx);
    else passes++;
    idleCycles(2, 1'b0);
  endtask

  task automatic test_zero_burst();
    logic [7:0] b [9];
    for (int k = 0; k < 9; k++) b[k] = 8'h00;
    runBurst(1'b1, b, 9, 0, 1'b0);
    checks++;
    if ({crcDone, crcErr, crcCalc} !== {2'b10, 8'h00})
      $display("[TB] FAIL zero_burst actual=%b_%h required=10_00", {crcDone, crcErr}, crcCalc);
    else passes++;
    idleCycles(5, 1'b0);
  endtask

  task automatic test_single_bit();
    logic [7:0] b [9];
    for (int k = 0; k < 9; k++) b[k] = 8'h00;
    b[0] = 8'h01;
    b[8] = 8'h07;
    runBurst(1'b1, b, 9, 0, 1'b0);
    checks++;
    if ({crcDone, crcErr, crcCalc, crcRx} !== {2'b10, 8'h07, 8'h07})
      $display("[TB] FAIL bit0_good actual=%b_%h_%h required=10_07_07", {crcDone, crcErr}, crcCalc, crcRx);
    else passes++;
    idleCycles(2, 1'b0);
    b[8] = 8'h06;
    runBurst(1'b1, b, 9, 0, 1'b0);
    checks++;
    if ({crcDone, crcErr, alertN, crcCalc, crcRx} !== {3'b110, 8'h07, 8'h06})
      $display("[TB] FAIL bit0_bad actual=%b_%h_%h required=110_07_06", {crcDone, crcErr, alertN}, crcCalc, crcRx);
    else passes++;
    idleCycles(6, 1'b0);
    checks++;
    if (errCnt !== 8'd1) $display("[TB] FAIL err_cnt_one actual=%0d required=1", errCnt);
    else passes++;
  endtask

  task automatic test_gaps();
    logic [7:0] b [9];
    for (int k = 0; k < 9; k++) b[k] = 8'h00;
    b[0] = 8'h80;
    b[1] = 8'h01;
    b[8] = 8'h9C;
    runBurst(1'b1, b, 9, 3, 1'b0);
    checks++;
    if ({crcDone, crcErr, busy, crcCalc} !== {3'b100, 8'h9C})
      $display("[TB] FAIL gap_burst actual=%b_%h required=100_9c", {crcDone, crcErr, busy}, crcCalc);
    else passes++;
    idleCycles(2, 1'b0);
  endtask

  task automatic test_mode_off();
    logic [7:0] b [9];
    for (int k = 0; k < 9; k++) b[k] = 8'hFF;
    runBurst(1'b0, b, 8, 1, 1'b1);
    checks++;
    if ({crcDone, crcErr, busy, crcRx} !== {3'b100, 8'h9C})
      $display("[TB] FAIL mode_off actual=%b_%h required=100_9c", {crcDone, crcErr, busy}, crcRx);
    else passes++;
    idleCycles(3, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1 [9];
    logic [7:0] b2 [9];
    idleCycles(1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      b1[k] = 8'($urandom);
      b2[k] = 8'($urandom);
    end
    b1[8] = burstCrc(b1) ^ 8'h5A;
    b2[8] = burstCrc(b2) ^ 8'h81;
    runBurst(1'b1, b1, 9, 0, 1'b0);
    runBurst(1'b1, b2, 9, 0, 1'b0);
    checks++;
    if ({crcDone, crcErr} !== 2'b11) $display("[TB] FAIL b2b_second_err actual=%b required=11", {crcDone, crcErr});
    else passes++;
    checks++;
    if ((cyc - lastDoneCyc) !== 9) $display("[TB] FAIL b2b_spacing actual=%0d required=9", cyc - lastDoneCyc);
    else passes++;
    idleCycles(1, 1'b1);
    checks++;
    if (errCnt !== 8'd1) $display("[TB] FAIL clr_with_err actual=%0d required=1", errCnt);
    else passes++;
    idleCycles(ALERT_PW + 1, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] b [9];
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
      b[8] = ($urandom_range(0, 1) == 1) ? burstCrc(b) : 8'($urandom);
      runBurst(1'($urandom_range(0, 1)), b, 9, 2, 1'b0);
    end
    idleCycles(ALERT_PW + 1, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] b [9];
    for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
    b[8] = burstCrc(b);
    runBurst(1'b1, b, 5, 0, 1'b0);
    stepCycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({busy, crcDone, crcErr, alertN, errCnt, crcCalc, crcRx} !== {4'b0001, 8'h00, 8'h00, 8'h00})
      $display("[TB] FAIL mid_reset actual=%b_%h_%h_%h required=0001_00_00_00",
               {busy, crcDone, crcErr, alertN}, errCnt, crcCalc, crcRx);
    else passes++;
    idleCycles(2, 1'b0);
    runBurst(1'b1, b, 9, 1, 1'b0);
    checks++;
    if ({crcDone, crcErr, crcRx} !== {2'b10, b[8]})
      $display("[TB] FAIL after_reset_burst actual=%b_%h required=10_%h", {crcDone, crcErr}, crcRx, b[8]);
    else passes++;
    idleCycles(1, 1'b0);
  endtask

  task automatic test_saturation();
    logic [7:0] b [9];
    for (int k = 0; k < 9; k++) b[k] = 8'h00;
    b[8] = 8'h01;
    for (int n = 0; n < 255; n++) runBurst(1'b1, b, 9, 0, 1'b0);
    idleCycles(1, 1'b0);
    checks++;
    if (errCnt !== 8'hFF) $display("[TB] FAIL cnt_255 actual=%h required=ff", errCnt);
    else passes++;
    runBurst(1'b1, b, 9, 0, 1'b0);
    idleCycles(1, 1'b0);
    checks++;
    if (errCnt !== 8'hFF) $display("[TB] FAIL cnt_saturate actual=%h required=ff", errCnt);
    else passes++;
    idleCycles(ALERT_PW + 1, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    crcEn   = 1'b0;
    beatVld = 1'b0;
    chkData = 8'h00;
    clrCnt  = 1'b0;
    test_reset();
    test_zero_burst();
    test_single_bit();
    test_gaps();
    test_mode_off();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/asu_ddr5_crc_check_x4.md
Name: asu_ddr5_crc_check_x4

Overview:
Receive-side DDR5 write-CRC checker for an x4 device. It captures a BL16 write burst plus its CRC from an 8-bit per-cycle beat bus: 8 data beats (64 bits) followed by 1 CRC beat. It recomputes the CRC, compares it with the received CRC, and reports mismatches as a result pulse, an active-low ALERT_n pulse and a saturating error count. It is the checking counterpart of asu_ddr5_crc_x4 and sits on the DRAM-model / loopback side of the write path.

Parameters:
ALERT_PW, 4, number of cycles alert_n_o is held low per error (>=1)
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_i  in  1  reset, synchronous, active-high
crc_en_i  in  1  CRC mode enable; sampled on the first beat of each burst and held for that burst
beat_vld_i  in  1  beat valid; when high, chk_data_i is consumed this cycle
chk_data_i  in  8  beat payload: data beats 0-7, then CRC beat 8
clr_cnt_i  in  1  clears err_cnt_o
busy_o  out  1  a burst is in progress (at least one beat accepted, result not yet issued)
crc_done_o  out  1  one-cycle pulse: burst complete
crc_err_o  out  1  one-cycle pulse coincident with crc_done_o: CRC mismatch
crc_calc_o  out  8  recomputed CRC of the last completed burst
crc_rx_o  out  8  received CRC of the last completed burst
alert_n_o  out  1  active-low error alert
err_cnt_o  out  ERR_CNT_W  saturating count of CRC errors

Behaviour:
- Reset values (rst_i high at an edge): busy_o=0, crc_done_o=0, crc_err_o=0, crc_calc_o=0x00, crc_rx_o=0x00, alert_n_o=1, err_cnt_o=0. The FSM goes to IDLE, the beat counter to 0 and the accumulator to 0x00. Reset mid-burst discards the partial burst and produces no done pulse.
- CRC function:
  - Polynomial x^8+x^2+x+1, init 0x00, no final XOR.
  - The 64-bit data is beat k bits [7:0] = D[8k+7:8k].
  - The result is bit-identical to asu_ddr5_crc_x4 for the same 8 beats.
  - Per-beat XOR contributions are linear; anchor values: only beat0 bit0 set -> 0x07; only beat0 bit7 set -> 0x89; only beat1 bit0 set -> 0x15.
- FSM states IDLE, DATA, CRCB:
  - IDLE: a valid beat is accepted as beat 0. The accumulator is loaded with beat 0's contribution, crc_en_i is latched into mode, and the FSM goes to DATA with counter=1.
  - DATA: each valid beat XORs its contribution into the accumulator and the counter increments. On beat 7: if mode=1 go to CRCB, else finish.
  - CRCB: the next valid beat is the received CRC, then finish.
  - Invalid cycles (beat_vld_i=0) in any state hold all state. There is no timeout.
- Finish, when the last beat is accepted at edge N:
  - At N+1: crc_done_o=1 for one cycle.
  - crc_calc_o = final accumulator.
  - crc_rx_o = CRC beat if mode=1, else unchanged.
  - crc_err_o = mode & (calc != rx).
  - The FSM returns to IDLE. crc_calc_o and crc_rx_o hold until the next finish.
- busy_o: high from the edge accepting beat 0 until the edge at which crc_done_o rises.
- Back-to-back bursts: a valid beat in the cycle crc_done_o is high is beat 0 of the next burst. There is no bubble.
- Alert:
  - On a crc_err_o pulse, alert_n_o goes low in the same cycle and stays low for ALERT_PW cycles.
  - A new error while alert is active reloads the timer to ALERT_PW.
- Error counter:
  - Increments on each crc_err_o pulse and saturates at all-ones.
  - clr_cnt_i sets it to 0.
  - clr_cnt_i together with an error pulse sets it to 1.
- Internal contract: latency from last beat to result is exactly 1 cycle.

Test Plan:
1. mode=1; 8 zero beats, CRC beat 0x00 -> crc_done_o pulse; crc_err_o=0; crc_calc_o=0x00; alert_n_o stays 1.
2. mode=1; beat0=0x01, beats1-7=0x00, CRC 0x07 -> no error; then the same data with CRC 0x06 -> crc_err_o=1, crc_calc_o=0x07, crc_rx_o=0x06, alert_n_o low exactly 4 cycles, err_cnt_o=1.
3. beat0=0x80, beat1=0x01, others 0, CRC 0x9C (0x89^0x15) with random beat_vld_i gaps -> no error. Check done arrives 1 cycle after the 9th valid beat and busy_o deasserts at the same edge.
4. mode=0; 8 beats of 0xFF -> done after the 8th beat, crc_err_o=0, crc_rx_o unchanged. Assert crc_en_i high mid-burst -> still an 8-beat burst.
5. Two back-to-back erroneous bursts with no idle cycle -> two done/err pulses 9 cycles apart. The second error reloads alert, so alert_n_o is low continuously until 4 cycles after the second error. err_cnt_o=2. Assert clr_cnt_i on the second error cycle -> err_cnt_o=1.
6. Assert rst_i after beat 4 -> no done pulse, all outputs at reset values. A clean burst afterwards checks correctly. Force 255 errors with ERR_CNT_W=8, then one more -> err_cnt_o stays 0xFF.
